// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48E1-style datapath slice.
//   DSP_W        datapath width of the X/Y/Z/P buses
//   ALU_*        alumode encodings understood by alu_core
//   pattern_match  masked compare used for pattern detect (mask bit 1 = ignore)
package dsp48_pkg;

    localparam int unsigned DSP_W = 48;

    // Arithmetic group (alumode[3:2] == 2'b00)
    localparam logic [3:0] ALU_ADD   = 4'b0000;  // Z + (X+Y+CIN)
    localparam logic [3:0] ALU_NZADD = 4'b0001;  // ~Z + (X+Y+CIN)
    localparam logic [3:0] ALU_NSUM  = 4'b0010;  // ~(Z+X+Y+CIN)
    localparam logic [3:0] ALU_ZSUB  = 4'b0011;  // Z - (X+Y+CIN)

    // Logic group
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_XNOR  = 4'b0101;
    localparam logic [3:0] ALU_AND   = 4'b1100;
    localparam logic [3:0] ALU_ANDN  = 4'b1101;  // X & ~Z
    localparam logic [3:0] ALU_OR    = 4'b1110;
    localparam logic [3:0] ALU_NOR   = 4'b1111;

    function automatic logic pattern_match(input logic [DSP_W-1:0] value,
                                           input logic [DSP_W-1:0] pattern,
                                           input logic [DSP_W-1:0] mask);
        return ((value ^ pattern) & ~mask) == '0;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU of the DSP48E1 post-mux stage.
// Ports:
//   x, y, z  in  DSP_W  mux outputs
//   am       in  4      alumode (operation select)
//   cin      in  1      carry input
//   result   out DSP_W  operation result, modulo 2^DSP_W
//   cout     out 1      bit DSP_W of the internal sum (inverted borrow for subtracts); 0 for logic ops
module alu_core
    import dsp48_pkg::*;
(
    input  logic [DSP_W-1:0] x,
    input  logic [DSP_W-1:0] y,
    input  logic [DSP_W-1:0] z,
    input  logic [3:0]       am,
    input  logic             cin,
    output logic [DSP_W-1:0] result,
    output logic             cout
);

    localparam int unsigned SW = DSP_W + 1;

    logic [SW-1:0]    s;
    logic [DSP_W-1:0] xyc;
    logic             arith;

    always_comb begin
        s      = '0;
        result = '0;
        cout   = 1'b0;
        arith  = 1'b0;
        // X+Y+CIN folded to DSP_W bits; only the subtract path uses it as one operand
        xyc    = x + y + DSP_W'(cin);

        case (am)
            ALU_ADD: begin
                arith = 1'b1;
                s     = {1'b0, z} + {1'b0, x} + {1'b0, y} + SW'(cin);
            end
            ALU_ZSUB: begin
                arith = 1'b1;
                s     = {1'b0, z} + {1'b0, ~xyc} + SW'(1);
            end
            ALU_NZADD: begin
                arith = 1'b1;
                s     = {1'b0, ~z} + {1'b0, x} + {1'b0, y} + SW'(cin);
            end
            ALU_NSUM: begin
                arith = 1'b1;
                s     = ~({1'b0, z} + {1'b0, x} + {1'b0, y} + SW'(cin));
            end
            ALU_XOR:  result = x ^ z;
            ALU_XNOR: result = ~(x ^ z);
            ALU_AND:  result = x & z;
            ALU_ANDN: result = x & ~z;
            ALU_OR:   result = x | z;
            ALU_NOR:  result = ~(x | z);
            default:  result = '0;
        endcase

        if (arith) begin
            result = s[DSP_W-1:0];
            cout   = s[DSP_W];
        end
    end

endmodule

// File: rtl/alu_preg.sv
// Post-mux ALU stage with optional control and P registers plus pattern detect.
// Ports:
//   clk, rst        clock and synchronous active-high reset (overrides all enables)
//   ce_ctrl         enable for the alumode/carryin registers
//   ce_p            enable for the P-stage registers
//   x_in/y_in/z_in  DSP_W-bit mux outputs
//   alumode         operation select, carryin = CIN
//   p, p_fb         result (p_fb feeds z_mux), carryout, pattern_detect
module alu_preg
    import dsp48_pkg::*;
#(
    parameter int unsigned      ALUMODEREG = 1,
    parameter int unsigned      CARRYINREG = 1,
    parameter int unsigned      PREG       = 1,
    parameter logic [DSP_W-1:0] PATTERN    = 48'h0,
    parameter logic [DSP_W-1:0] MASK       = 48'h3FFF_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_ctrl,
    input  logic             ce_p,
    input  logic [DSP_W-1:0] x_in,
    input  logic [DSP_W-1:0] y_in,
    input  logic [DSP_W-1:0] z_in,
    input  logic [3:0]       alumode,
    input  logic             carryin,
    output logic [DSP_W-1:0] p,
    output logic             carryout,
    output logic             pattern_detect,
    output logic [DSP_W-1:0] p_fb
);

    logic [3:0]       am_eff;
    logic             cin_eff;
    logic [DSP_W-1:0] p_d;
    logic             cout_d;
    logic             pd_d;

    // Control stage
    if (ALUMODEREG != 0) begin : g_am_reg
        logic [3:0] am_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                am_q <= '0;
            end else if (ce_ctrl) begin
                am_q <= alumode;
            end
        end
        assign am_eff = am_q;
    end else begin : g_am_comb
        assign am_eff = alumode;
    end

    if (CARRYINREG != 0) begin : g_cin_reg
        logic cin_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                cin_q <= 1'b0;
            end else if (ce_ctrl) begin
                cin_q <= carryin;
            end
        end
        assign cin_eff = cin_q;
    end else begin : g_cin_comb
        assign cin_eff = carryin;
    end

    alu_core u_alu_core (
        .x      (x_in),
        .y      (y_in),
        .z      (z_in),
        .am     (am_eff),
        .cin    (cin_eff),
        .result (p_d),
        .cout   (cout_d)
    );

    // Detect is evaluated on next-P so it lines up with p when registered
    assign pd_d = pattern_match(p_d, PATTERN, MASK);

    // P stage
    if (PREG != 0) begin : g_p_reg
        logic [DSP_W-1:0] p_q;
        logic             cout_q;
        logic             pd_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q    <= '0;
                cout_q <= 1'b0;
                pd_q   <= 1'b0;
            end else if (ce_p) begin
                p_q    <= p_d;
                cout_q <= cout_d;
                pd_q   <= pd_d;
            end
        end
        assign p              = p_q;
        assign carryout       = cout_q;
        assign pattern_detect = pd_q;
    end else begin : g_p_comb
        assign p              = p_d;
        assign carryout       = cout_d;
        assign pattern_detect = pd_d;
    end

    assign p_fb = p;

endmodule

// File: tb/tb_alu_preg.sv
module tb_alu_preg;
    import dsp48_pkg::*;

    localparam logic [47:0] ONES     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MASK_2   = 48'h3FFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, ce_ctrl, ce_p, carryin, use_fb;
    logic [47:0] x_in, y_in, z_drv, z_reg;
    logic [3:0]  alumode;

    logic [47:0] p1, pfb1, p2, pfb2;
    logic        co1, pd1, co2, pd2;

    int n_vec = 0;
    int n_err = 0;

    // Reference state of the registered instance
    logic [3:0]  m_am;
    logic        m_cin;
    logic [47:0] m_p;
    logic        m_co, m_pd;

    always #5 clk = ~clk;

    assign z_reg = use_fb ? pfb1 : z_drv;

    alu_preg #(
        .ALUMODEREG (1),
        .CARRYINREG (1),
        .PREG       (1),
        .PATTERN    (48'h0),
        .MASK       (48'h0)
    ) u_dut_reg (
        .clk            (clk),
        .rst            (rst),
        .ce_ctrl        (ce_ctrl),
        .ce_p           (ce_p),
        .x_in           (x_in),
        .y_in           (y_in),
        .z_in           (z_reg),
        .alumode        (alumode),
        .carryin        (carryin),
        .p              (p1),
        .carryout       (co1),
        .pattern_detect (pd1),
        .p_fb           (pfb1)
    );

    alu_preg #(
        .ALUMODEREG (0),
        .CARRYINREG (0),
        .PREG       (0)
    ) u_dut_comb (
        .clk            (clk),
        .rst            (rst),
        .ce_ctrl        (ce_ctrl),
        .ce_p           (ce_p),
        .x_in           (x_in),
        .y_in           (y_in),
        .z_in           (z_drv),
        .alumode        (alumode),
        .carryin        (carryin),
        .p              (p2),
        .carryout       (co2),
        .pattern_detect (pd2),
        .p_fb           (pfb2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {carryout, result}; plain integer arithmetic modulo 2^49
    function automatic logic [48:0] ref_alu(input logic [47:0] x, input logic [47:0] y,
                                            input logic [47:0] z, input logic [3:0] am,
                                            input logic ci);
        longint unsigned a, vx, vy, vz, vc, m48, m49;
        vx  = x;
        vy  = y;
        vz  = z;
        vc  = ci;
        m48 = 64'h1_0000_0000_0000;
        m49 = 2 * m48;
        case (am)
            4'b0000: a = vz + vx + vy + vc;
            4'b0011: a = m48 + vz - ((vx + vy + vc) % m48);
            4'b0001: a = (m48 - 1) - vz + vx + vy + vc;
            4'b0010: a = (m49 - 1) - ((vz + vx + vy + vc) % m49);
            4'b0100: return {1'b0, x ^ z};
            4'b0101: return {1'b0, ~(x ^ z)};
            4'b1100: return {1'b0, x & z};
            4'b1101: return {1'b0, x & ~z};
            4'b1110: return {1'b0, x | z};
            4'b1111: return {1'b0, ~(x | z)};
            default: return 49'h0;
        endcase
        return 49'(a % m49);
    endfunction

    // One clock: drive at negedge, check combinational instance, advance model at posedge, check
    task automatic step(input logic r, input logic cc, input logic cp,
                        input logic [47:0] x, input logic [47:0] y, input logic [47:0] z,
                        input logic fb, input logic [3:0] am, input logic ci);
        logic [48:0] comb, nxt;
        @(negedge clk);
        rst     = r;
        ce_ctrl = cc;
        ce_p    = cp;
        x_in    = x;
        y_in    = y;
        z_drv   = z;
        use_fb  = fb;
        alumode = am;
        carryin = ci;
        #1;
        comb = ref_alu(x, y, z, am, ci);
        check("comb_p", 64'(p2), 64'(comb[47:0]));
        check("comb_co", 64'(co2), 64'(comb[48]));
        check("comb_pd", 64'(pd2), 64'((comb[47:0] & ~MASK_2) == 48'h0));
        nxt = ref_alu(x, y, fb ? m_p : z, m_am, m_cin);
        @(posedge clk);
        if (r) begin
            m_am  = '0;
            m_cin = 1'b0;
            m_p   = '0;
            m_co  = 1'b0;
            m_pd  = 1'b0;
        end else begin
            if (cp) begin
                m_p  = nxt[47:0];
                m_co = nxt[48];
                m_pd = (nxt[47:0] == 48'h0);
            end
            if (cc) begin
                m_am  = am;
                m_cin = ci;
            end
        end
        #1;
        check("reg_p", 64'(p1), 64'(m_p));
        check("reg_co", 64'(co1), 64'(m_co));
        check("reg_pd", 64'(pd1), 64'(m_pd));
        check("reg_pfb", 64'(pfb1), 64'(m_p));
    endtask

    initial begin
        logic [3:0]  codes [10];
        logic [47:0] rx, ry, rz;
        logic [3:0]  ram;
        codes = '{ALU_ADD, ALU_NZADD, ALU_NSUM, ALU_ZSUB, ALU_XOR,
                  ALU_XNOR, ALU_AND, ALU_ANDN, ALU_OR, ALU_NOR};
        m_am = '0; m_cin = 1'b0; m_p = '0; m_co = 1'b0; m_pd = 1'b0;
        rst = 1'b1; ce_ctrl = 1'b0; ce_p = 1'b0; carryin = 1'b0; use_fb = 1'b0;
        x_in = '0; y_in = '0; z_drv = '0; alumode = '0;

        // Reset state
        step(1, 1, 1, 48'h0, 48'h0, 48'h0, 0, ALU_ADD, 0);
        check("rst_p", 64'(p1), 64'h0);
        check("rst_co", 64'(co1), 64'h0);
        check("rst_pd", 64'(pd1), 64'h0);

        // 5+7+1+100 with control latency
        repeat (2) step(0, 1, 1, 48'd5, 48'd7, 48'd100, 0, ALU_ADD, 1);
        check("add_p", 64'(p1), 64'd113);
        check("add_co", 64'(co1), 64'h0);

        // Subtract: no borrow, then borrow
        repeat (2) step(0, 1, 1, 48'd3, 48'd4, 48'd10, 0, ALU_ZSUB, 0);
        check("sub_p", 64'(p1), 64'd3);
        check("sub_co", 64'(co1), 64'h1);
        step(0, 1, 1, 48'd1, 48'd0, 48'd0, 0, ALU_ZSUB, 0);
        check("subneg_p", 64'(p1), 64'(ONES));
        check("subneg_co", 64'(co1), 64'h0);

        // Wrap to zero
        repeat (2) step(0, 1, 1, 48'd1, 48'd0, ONES, 0, ALU_ADD, 0);
        check("wrap_p", 64'(p1), 64'h0);
        check("wrap_co", 64'(co1), 64'h1);
        check("wrap_pd", 64'(pd1), 64'h1);

        // Accumulate through p_fb, hold, then reset
        step(1, 1, 1, 48'd0, 48'd0, 48'd0, 0, ALU_ADD, 0);
        repeat (10) step(0, 1, 1, 48'd1, 48'd0, 48'd0, 1, ALU_ADD, 0);
        check("acc_p", 64'(p1), 64'd10);
        repeat (3) step(0, 1, 0, 48'd1, 48'd0, 48'd0, 1, ALU_ADD, 0);
        check("hold_p", 64'(p1), 64'd10);
        step(1, 1, 1, 48'd1, 48'd0, 48'd0, 1, ALU_ADD, 0);
        check("accrst_p", 64'(p1), 64'h0);

        // Logic ops ignore Y
        repeat (2) step(0, 1, 1, 48'hF0F0, 48'hFFFF, 48'h0FF0, 0, ALU_XOR, 0);
        check("xor_p", 64'(p1), 64'hFF00);
        check("xor_co", 64'(co1), 64'h0);
        repeat (2) step(0, 1, 1, 48'hF0F0, 48'hFFFF, 48'h0FF0, 0, ALU_AND, 1);
        check("and_p", 64'(p1), 64'h00F0);
        check("and_co", 64'(co1), 64'h0);

        // Reset beats ce_p; combinational instance still follows inputs
        repeat (2) step(0, 1, 1, 48'd5, 48'd7, 48'd100, 0, ALU_ADD, 1);
        step(1, 1, 1, 48'd5, 48'd7, 48'd100, 0, ALU_ADD, 1);
        check("rstce_p", 64'(p1), 64'h0);
        check("rstce_co", 64'(co1), 64'h0);
        check("rstce_pd", 64'(pd1), 64'h0);
        check("comb_live_p", 64'(p2), 64'd113);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rx  = 48'({$urandom(), $urandom()});
            ry  = 48'({$urandom(), $urandom()});
            rz  = 48'({$urandom(), $urandom()});
            if ($urandom_range(7) == 0) rx = ONES;
            if ($urandom_range(7) == 0) ry = 48'h0;
            if ($urandom_range(7) == 0) rz = 48'($urandom_range(3));
            ram = ($urandom_range(4) == 0) ? 4'($urandom()) : codes[$urandom_range(9)];
            step(($urandom_range(31) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                 rx, ry, rz, 1'($urandom_range(1)), ram, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
